tmds_decoder: RTL and testbench
===============================

TMDS_DECODER -- requirements
Module: tmds_decoder

Interface
REQ-001 SHALL have parameter PREAMBLE_LEN, default 8, the number of consecutive preamble cycles needed to arm a guard band.
REQ-002 SHALL have port tmds_clk, input, 1 bit: the single clock; one TMDS symbol per rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have port symbol, input, 10 bits: the received, word-aligned TMDS symbol.
REQ-005 SHALL have port tmds_channel_num, input, 2 bits: channel index 0..2; static; value 3 is illegal.
REQ-006 SHALL have port ctl_in, input, 4 bits: {CTL3..CTL0} from the channel 1/2 decoders, aligned by the top level to the current symbol.
REQ-007 SHALL have port data, output, 8 bits: decoded video byte.
REQ-008 SHALL have port aux_data, output, 4 bits: decoded TERC4 nibble.
REQ-009 SHALL have port ctrl_data, output, 2 bits: decoded control code.
REQ-010 SHALL have port period_type, output, 2 bits: 00 control, 01 data island, 10 video.
REQ-011 SHALL have port guard, output, 1 bit: current symbol is a guard band.
REQ-012 SHALL have port data_valid, output, 1 bit: data or aux_data holds a valid payload.
REQ-013 SHALL have port sym_err, output, 1 bit: symbol illegal for the current state.
REQ-014 SHALL have port err_count, output, 16 bits: error counter (see Configuration).

Function
REQ-015 All outputs SHALL be registered, with latency exactly 1 cycle from symbol to outputs.
REQ-016 Control symbols SHALL decode as 1101010100->00, 0010101011->01, 0101010100->10, 1010101011->11.
REQ-017 Video decode SHALL use: q=symbol[9]?~symbol[7:0]:symbol[7:0]; data[0]=q[0]; data[i]=q[i]^q[i-1] if symbol[8], else ~(q[i]^q[i-1]), for i=1..7.
REQ-018 TERC4 decode SHALL be the inverse of the 16-entry HDMI TERC4 table (0000->1010011100 ... 1111->1011000011); any other symbol is non-TERC4.
REQ-019 FSM states SHALL be CTRL, GUARD_V, GUARD_D, VIDEO, ISLAND.
REQ-020 The FSM SHALL reset to CTRL; all three channel instances track the same FSM via ctl_in.
REQ-021 In CTRL, a 4-bit preamble counter SHALL count consecutive control-symbol cycles with ctl_in equal to 0001 (video) or 0101 (island), saturating at 15.
REQ-022 The preamble counter SHALL clear when ctl_in changes pattern or on any non-control symbol.
REQ-023 The arm condition SHALL be count>=PREAMBLE_LEN.
REQ-024 Video guard symbols SHALL be: ch0 1011001100, ch1 0100110011, ch2 1011001100.
REQ-025 Island guard symbols SHALL be: ch1/ch2 0100110011; ch0 any TERC4 symbol decoding to 11xx.
REQ-026 CTRL SHALL go to GUARD_V (or GUARD_D) on a matching guard symbol when armed for that type; the output reports guard=1 and period_type 10 (or 01).
REQ-027 A guard symbol in CTRL when not armed, or any non-control non-guard symbol in CTRL, SHALL raise sym_err, and the FSM SHALL stay in CTRL.
REQ-028 In GUARD_x, a second matching guard symbol SHALL move to VIDEO or ISLAND (guard=1); any other symbol SHALL raise sym_err and return to CTRL (a control symbol is also decoded).
REQ-029 VIDEO SHALL decode every non-control symbol with data_valid=1; a control symbol SHALL move to CTRL in the same cycle, with period_type 00 output for that symbol.
REQ-030 In ISLAND, a TERC4 symbol SHALL give aux_data and data_valid=1, except that on ch1/ch2 0100110011 gives guard=1 with data_valid=0.
REQ-031 In ISLAND, a control symbol SHALL move to CTRL; any other symbol SHALL raise sym_err and the FSM SHALL remain in ISLAND.
REQ-032 data and aux_data SHALL hold their previous values when data_valid=0.
REQ-033 sym_err SHALL be a 1-cycle pulse per offending symbol.
REQ-034 Behaviour with tmds_channel_num=3 is undefined.

Reset
REQ-035 While rst=1 at a clock edge, the FSM SHALL go to CTRL, the preamble counter to 0, and all outputs including err_count to 0.
REQ-036 Reset mid-video or mid-island SHALL abort immediately; the first post-reset symbol is treated in CTRL.

Configuration
REQ-037 With macro TMDS_DECODER_ERR_CNT_EN defined, err_count SHALL increment on each sym_err, saturate at 16'hFFFF, and clear only on rst.
REQ-038 Without TMDS_DECODER_ERR_CNT_EN, err_count SHALL be constant 0 and no counter logic SHALL be present.

Verification
REQ-039 Reset test: rst=1 for 2 cycles with random symbols -> all outputs 0, period_type=00.
REQ-040 Control test: ch0, symbol 0010101011 -> next cycle ctrl_data=01, period_type=00, sym_err=0.
REQ-041 Video entry: ch0, 8 x 1101010100 with ctl_in=0001, then 2 x 1011001100, then 0100000000 -> guard=1 for 2 cycles, then period_type=10, data=8'h00, data_valid=1.
REQ-042 Island: ch1, 8 x control with ctl_in=0101, 2 x 0100110011, 1010011100, then 1101010100 -> aux_data=0000 and period_type=01, then period_type=00.
REQ-043 Short preamble: 7 preamble cycles then 1011001100 -> sym_err=1, state stays CTRL; with TMDS_DECODER_ERR_CNT_EN, err_count=1.
REQ-044 Island error: symbol 1111111111 in ISLAND -> sym_err=1 for one cycle, period_type stays 01.

Source files
------------

// File: rtl/tmds_decoder.sv
// TMDS channel decoder: control, video and TERC4 symbols tracked by a period FSM.
// Define TMDS_DECODER_ERR_CNT_EN to build the saturating symbol-error counter.
module tmds_decoder #(
  parameter int PREAMBLE_LEN = 8
) (
  input  logic        tmds_clk,
  input  logic        rst,
  input  logic [9:0]  symbol,
  input  logic [1:0]  tmds_channel_num,
  input  logic [3:0]  ctl_in,
  output logic [7:0]  data,
  output logic [3:0]  aux_data,
  output logic [1:0]  ctrl_data,
  output logic [1:0]  period_type,
  output logic        guard,
  output logic        data_valid,
  output logic        sym_err,
  output logic [15:0] err_count
);

  typedef enum logic [2:0] {CTRL, GUARD_V, GUARD_D, VIDEO, ISLAND} state_t;

  localparam logic [1:0] PT_CTRL   = 2'b00;
  localparam logic [1:0] PT_ISLAND = 2'b01;
  localparam logic [1:0] PT_VIDEO  = 2'b10;

  state_t      state;
  logic [3:0]  pre_cnt;
  logic        pre_island;

  logic        is_ctrl;
  logic [1:0]  ctrl_code;
  logic        terc4_ok;
  logic [3:0]  terc4_nib;
  logic [7:0]  q;
  logic [7:0]  vbyte;
  logic        is_g12;
  logic        is_vguard;
  logic        is_dguard;
  logic        isl_guard;
  logic        armed_v;
  logic        armed_d;
  logic        illegal;

  always_comb begin
    is_ctrl   = 1'b1;
    ctrl_code = 2'b00;
    case (symbol)
      10'b1101010100: ctrl_code = 2'b00;
      10'b0010101011: ctrl_code = 2'b01;
      10'b0101010100: ctrl_code = 2'b10;
      10'b1010101011: ctrl_code = 2'b11;
      default:        is_ctrl   = 1'b0;
    endcase

    terc4_ok  = 1'b1;
    terc4_nib = 4'h0;
    case (symbol)
      10'b1010011100: terc4_nib = 4'h0;
      10'b1001100011: terc4_nib = 4'h1;
      10'b1011100100: terc4_nib = 4'h2;
      10'b1011100010: terc4_nib = 4'h3;
      10'b0101110001: terc4_nib = 4'h4;
      10'b0100011110: terc4_nib = 4'h5;
      10'b0110001110: terc4_nib = 4'h6;
      10'b0100111100: terc4_nib = 4'h7;
      10'b1011001100: terc4_nib = 4'h8;
      10'b0100111001: terc4_nib = 4'h9;
      10'b0110011100: terc4_nib = 4'hA;
      10'b1011000110: terc4_nib = 4'hB;
      10'b1010001110: terc4_nib = 4'hC;
      10'b1001110001: terc4_nib = 4'hD;
      10'b0101100011: terc4_nib = 4'hE;
      10'b1011000011: terc4_nib = 4'hF;
      default:        terc4_ok  = 1'b0;
    endcase

    q        = symbol[9] ? ~symbol[7:0] : symbol[7:0];
    vbyte    = '0;
    vbyte[0] = q[0];
    for (int i = 1; i < 8; i++) begin
      vbyte[i] = symbol[8] ? (q[i] ^ q[i-1]) : ~(q[i] ^ q[i-1]);
    end
  end

  // Channel 1 shares the 0100110011 guard between video and island; arming type disambiguates.
  always_comb begin
    is_g12    = (symbol == 10'b0100110011);
    is_vguard = (tmds_channel_num == 2'd1) ? is_g12 : (symbol == 10'b1011001100);
    is_dguard = (tmds_channel_num == 2'd0) ? (terc4_ok && (terc4_nib[3:2] == 2'b11)) : is_g12;
    isl_guard = is_g12 && (tmds_channel_num != 2'd0);
    armed_v   = !pre_island && (int'(pre_cnt) >= PREAMBLE_LEN);
    armed_d   =  pre_island && (int'(pre_cnt) >= PREAMBLE_LEN);

    illegal = 1'b0;
    case (state)
      CTRL:    illegal = !is_ctrl && !(armed_v && is_vguard) && !(armed_d && is_dguard);
      GUARD_V: illegal = !is_vguard;
      GUARD_D: illegal = !is_dguard;
      VIDEO:   illegal = 1'b0;
      ISLAND:  illegal = !is_ctrl && !isl_guard && !terc4_ok;
      default: illegal = 1'b0;
    endcase
  end

  always_ff @(posedge tmds_clk) begin
    if (rst) begin
      state       <= CTRL;
      pre_cnt     <= '0;
      pre_island  <= 1'b0;
      data        <= '0;
      aux_data    <= '0;
      ctrl_data   <= '0;
      period_type <= PT_CTRL;
      guard       <= 1'b0;
      data_valid  <= 1'b0;
      sym_err     <= 1'b0;
    end else begin
      guard      <= 1'b0;
      data_valid <= 1'b0;
      sym_err    <= illegal;
      pre_cnt    <= '0;
      if (is_ctrl) ctrl_data <= ctrl_code;

      case (state)
        CTRL: begin
          period_type <= PT_CTRL;
          if (is_ctrl) begin
            // A preamble run restarts at 1 when the pattern switches between video and island.
            if (ctl_in == 4'b0001 || ctl_in == 4'b0101) begin
              pre_island <= ctl_in[2];
              if (pre_cnt != 4'd0 && pre_island == ctl_in[2])
                pre_cnt <= (pre_cnt == 4'hF) ? 4'hF : pre_cnt + 4'd1;
              else
                pre_cnt <= 4'd1;
            end
          end else if (armed_v && is_vguard) begin
            state       <= GUARD_V;
            guard       <= 1'b1;
            period_type <= PT_VIDEO;
          end else if (armed_d && is_dguard) begin
            state       <= GUARD_D;
            guard       <= 1'b1;
            period_type <= PT_ISLAND;
          end
        end
        GUARD_V: begin
          if (is_vguard) begin
            state       <= VIDEO;
            guard       <= 1'b1;
            period_type <= PT_VIDEO;
          end else begin
            state       <= CTRL;
            period_type <= PT_CTRL;
          end
        end
        GUARD_D: begin
          if (is_dguard) begin
            state       <= ISLAND;
            guard       <= 1'b1;
            period_type <= PT_ISLAND;
          end else begin
            state       <= CTRL;
            period_type <= PT_CTRL;
          end
        end
        VIDEO: begin
          if (is_ctrl) begin
            state       <= CTRL;
            period_type <= PT_CTRL;
          end else begin
            data        <= vbyte;
            data_valid  <= 1'b1;
            period_type <= PT_VIDEO;
          end
        end
        ISLAND: begin
          period_type <= PT_ISLAND;
          if (is_ctrl) begin
            state       <= CTRL;
            period_type <= PT_CTRL;
          end else if (isl_guard) begin
            guard <= 1'b1;
          end else if (terc4_ok) begin
            aux_data   <= terc4_nib;
            data_valid <= 1'b1;
          end
        end
        default: begin
          state       <= CTRL;
          period_type <= PT_CTRL;
        end
      endcase
    end
  end

`ifdef TMDS_DECODER_ERR_CNT_EN
  always_ff @(posedge tmds_clk) begin
    if (rst)
      err_count <= '0;
    else if (illegal && err_count != 16'hFFFF)
      err_count <= err_count + 16'd1;
  end
`else
  assign err_count = '0;
`endif

endmodule

// File: tb/tb_tmds_decoder.sv
// Directed self-checking bench for tmds_decoder: reset, control, video and island
// periods, short preamble, guard aborts and reset mid-period.
module tb_tmds_decoder;

  localparam logic [9:0] C00 = 10'b1101010100;
  localparam logic [9:0] C01 = 10'b0010101011;
  localparam logic [9:0] C10 = 10'b0101010100;
  localparam logic [9:0] C11 = 10'b1010101011;
  localparam logic [9:0] VG0 = 10'b1011001100;
  localparam logic [9:0] G12 = 10'b0100110011;

  logic        tmds_clk = 1'b0;
  logic        rst = 1'b1;
  logic [9:0]  symbol = '0;
  logic [1:0]  tmds_channel_num = 2'd0;
  logic [3:0]  ctl_in = '0;
  logic [7:0]  data;
  logic [3:0]  aux_data;
  logic [1:0]  ctrl_data;
  logic [1:0]  period_type;
  logic        guard;
  logic        data_valid;
  logic        sym_err;
  logic [15:0] err_count;

  int checks = 0;
  int failures = 0;
  int exp_errs = 0;

  tmds_decoder #(.PREAMBLE_LEN(8)) dut (
    .tmds_clk(tmds_clk),
    .rst(rst),
    .symbol(symbol),
    .tmds_channel_num(tmds_channel_num),
    .ctl_in(ctl_in),
    .data(data),
    .aux_data(aux_data),
    .ctrl_data(ctrl_data),
    .period_type(period_type),
    .guard(guard),
    .data_valid(data_valid),
    .sym_err(sym_err),
    .err_count(err_count)
  );

  always #5 tmds_clk = ~tmds_clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog got=timeout exp=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Inputs change on the falling edge; outputs are sampled 1 ns after the rising edge.
  task automatic applyStimulus(input logic [9:0] s, input logic [3:0] c, input logic r);
    @(negedge tmds_clk);
    symbol = s;
    ctl_in = c;
    rst    = r;
    @(posedge tmds_clk);
    #1;
  endtask

  task automatic resetDut(input logic [1:0] ch);
    tmds_channel_num = ch;
    applyStimulus(10'($urandom_range(0, 1023)), 4'($urandom_range(0, 15)), 1'b1);
    applyStimulus(10'($urandom_range(0, 1023)), 4'($urandom_range(0, 15)), 1'b1);
    exp_errs = 0;
  endtask

  task automatic preamble(input int n, input logic [3:0] c);
    for (int i = 0; i < n; i++) applyStimulus(C00, c, 1'b0);
  endtask

  task automatic cmp(input string tag, input string field, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("[TB] FAIL %s.%s got=%h exp=%h", tag, field, got, exp);
    end
  endtask

  task automatic checkOutput(input string tag, input logic [1:0] pt, input logic g, input logic dv,
                             input logic e, input logic [7:0] d, input logic [3:0] a,
                             input logic [1:0] c);
    logic [15:0] exp_cnt;
    if (e) exp_errs++;
`ifdef TMDS_DECODER_ERR_CNT_EN
    exp_cnt = 16'(exp_errs);
`else
    exp_cnt = 16'd0;
`endif
    cmp(tag, "period_type", {14'd0, period_type}, {14'd0, pt});
    cmp(tag, "guard",       {15'd0, guard},       {15'd0, g});
    cmp(tag, "data_valid",  {15'd0, data_valid},  {15'd0, dv});
    cmp(tag, "sym_err",     {15'd0, sym_err},     {15'd0, e});
    cmp(tag, "data",        {8'd0, data},         {8'd0, d});
    cmp(tag, "aux_data",    {12'd0, aux_data},    {12'd0, a});
    cmp(tag, "ctrl_data",   {14'd0, ctrl_data},   {14'd0, c});
    cmp(tag, "err_count",   err_count,            exp_cnt);
  endtask

  initial begin
    // Reset with random symbols
    resetDut(2'd0);
    checkOutput("reset", 2'b00, 0, 0, 0, 8'h00, 4'h0, 2'b00);

    // Control decode
    applyStimulus(C01, 4'b0000, 1'b0);
    checkOutput("ctrl01", 2'b00, 0, 0, 0, 8'h00, 4'h0, 2'b01);
    applyStimulus(C11, 4'b0000, 1'b0);
    checkOutput("ctrl11", 2'b00, 0, 0, 0, 8'h00, 4'h0, 2'b11);

    // Video entry on channel 0 with exactly PREAMBLE_LEN preamble cycles
    preamble(8, 4'b0001);
    checkOutput("preamble_v", 2'b00, 0, 0, 0, 8'h00, 4'h0, 2'b00);
    applyStimulus(VG0, 4'b0001, 1'b0);
    checkOutput("guard_v1", 2'b10, 1, 0, 0, 8'h00, 4'h0, 2'b00);
    applyStimulus(VG0, 4'b0001, 1'b0);
    checkOutput("guard_v2", 2'b10, 1, 0, 0, 8'h00, 4'h0, 2'b00);
    applyStimulus(10'b0100000000, 4'b0000, 1'b0);
    checkOutput("video00", 2'b10, 0, 1, 0, 8'h00, 4'h0, 2'b00);
    applyStimulus(10'b0100000001, 4'b0000, 1'b0);
    checkOutput("video03", 2'b10, 0, 1, 0, 8'h03, 4'h0, 2'b00);
    applyStimulus(10'b1000000000, 4'b0000, 1'b0);
    checkOutput("videoFF", 2'b10, 0, 1, 0, 8'hFF, 4'h0, 2'b00);
    applyStimulus(C10, 4'b0000, 1'b0);
    checkOutput("video_exit", 2'b00, 0, 0, 0, 8'hFF, 4'h0, 2'b10);

    // One preamble cycle short: guard is rejected, FSM stays in control
    preamble(7, 4'b0001);
    applyStimulus(VG0, 4'b0001, 1'b0);
    checkOutput("short_pre", 2'b00, 0, 0, 1, 8'hFF, 4'h0, 2'b00);
    applyStimulus(C00, 4'b0000, 1'b0);
    checkOutput("short_pre_after", 2'b00, 0, 0, 0, 8'hFF, 4'h0, 2'b00);

    // Data island on channel 1
    resetDut(2'd1);
    preamble(8, 4'b0101);
    applyStimulus(G12, 4'b0101, 1'b0);
    checkOutput("guard_d1", 2'b01, 1, 0, 0, 8'h00, 4'h0, 2'b00);
    applyStimulus(G12, 4'b0101, 1'b0);
    checkOutput("guard_d2", 2'b01, 1, 0, 0, 8'h00, 4'h0, 2'b00);
    applyStimulus(10'b1010011100, 4'b0000, 1'b0);
    checkOutput("aux0", 2'b01, 0, 1, 0, 8'h00, 4'h0, 2'b00);
    applyStimulus(10'b1011000011, 4'b0000, 1'b0);
    checkOutput("auxF", 2'b01, 0, 1, 0, 8'h00, 4'hF, 2'b00);
    applyStimulus(G12, 4'b0000, 1'b0);
    checkOutput("isl_guard", 2'b01, 1, 0, 0, 8'h00, 4'hF, 2'b00);
    applyStimulus(10'b1111111111, 4'b0000, 1'b0);
    checkOutput("isl_err", 2'b01, 0, 0, 1, 8'h00, 4'hF, 2'b00);
    applyStimulus(10'b0100011110, 4'b0000, 1'b0);
    checkOutput("aux5", 2'b01, 0, 1, 0, 8'h00, 4'h5, 2'b00);
    applyStimulus(C00, 4'b0000, 1'b0);
    checkOutput("isl_exit", 2'b00, 0, 0, 0, 8'h00, 4'h5, 2'b00);

    // Guard band aborted by a control symbol, then a stray data symbol in control
    preamble(8, 4'b0101);
    applyStimulus(G12, 4'b0101, 1'b0);
    checkOutput("abort_g", 2'b01, 1, 0, 0, 8'h00, 4'h5, 2'b00);
    applyStimulus(C11, 4'b0000, 1'b0);
    checkOutput("abort_ctl", 2'b00, 0, 0, 1, 8'h00, 4'h5, 2'b11);
    applyStimulus(10'b0100000000, 4'b0000, 1'b0);
    checkOutput("ctrl_bad", 2'b00, 0, 0, 1, 8'h00, 4'h5, 2'b11);

    // Island on channel 0 uses a TERC4 11xx symbol as its guard
    resetDut(2'd0);
    preamble(8, 4'b0101);
    applyStimulus(10'b1010001110, 4'b0101, 1'b0);
    checkOutput("g_d0_1", 2'b01, 1, 0, 0, 8'h00, 4'h0, 2'b00);
    applyStimulus(10'b1010001110, 4'b0101, 1'b0);
    checkOutput("g_d0_2", 2'b01, 1, 0, 0, 8'h00, 4'h0, 2'b00);
    applyStimulus(10'b1010001110, 4'b0000, 1'b0);
    checkOutput("isl0_C", 2'b01, 0, 1, 0, 8'h00, 4'hC, 2'b00);
    applyStimulus(VG0, 4'b0000, 1'b0);
    checkOutput("isl0_8", 2'b01, 0, 1, 0, 8'h00, 4'h8, 2'b00);

    // Reset in the middle of a video period
    resetDut(2'd0);
    preamble(8, 4'b0001);
    applyStimulus(VG0, 4'b0001, 1'b0);
    applyStimulus(VG0, 4'b0001, 1'b0);
    applyStimulus(10'b0100000001, 4'b0000, 1'b0);
    checkOutput("pre_abort", 2'b10, 0, 1, 0, 8'h03, 4'h0, 2'b00);
    applyStimulus(10'b0100000001, 4'b0000, 1'b1);
    exp_errs = 0;
    checkOutput("mid_reset", 2'b00, 0, 0, 0, 8'h00, 4'h0, 2'b00);
    applyStimulus(10'b0100000000, 4'b0000, 1'b0);
    checkOutput("post_reset", 2'b00, 0, 0, 1, 8'h00, 4'h0, 2'b00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
